llc_bus_queue: RTL and testbench



---
 rtl/llc_bus_queue_pkg.sv | 42 ++++
 rtl/llc_bus_fifo.sv | 52 +++++
 rtl/llc_bus_queue.sv | 134 +++++++++++++
 tb/tb_llc_bus_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_bus_queue_pkg.sv
// Shared LLC / bus-queue definitions: bus operation and snoop encodings, queue FSM states.
package llc_bus_queue_pkg;

  localparam int ADDR_BITS        = 32;
  localparam int BYTE_OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    HITM  = 2'd1,
    NOHIT = 2'd2
  } snp_rslt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BACKOFF,
    ST_RESPOND
  } bq_state_t;

  // The reserved snoop encoding collapses to NOHIT.
  function automatic snp_rslt_t snoop_sanitize(input snp_rslt_t s);
    snp_rslt_t r;
    case (s)
      HIT:     r = HIT;
      HITM:    r = HITM;
      default: r = NOHIT;
    endcase
    return r;
  endfunction

  function automatic logic op_retryable(input bus_op_t op);
    return (op == READ) || (op == RWIM);
  endfunction

endpackage

// File: rtl/llc_bus_fifo.sv
// Synchronous FIFO for queued bus operations; head entry visible combinationally.
module llc_bus_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/llc_bus_queue.sv
// In-order bus request queue below the LLC: issues one op at a time, retries HITM reads.
//
// state      | meaning
// IDLE       | waiting for a queued operation
// ISSUE      | head op driven on the bus until bus_ack
// BACKOFF    | bus released after a HITM snoop, counting down to re-issue
// RESPOND    | one-cycle completion pulse, head popped
module llc_bus_queue #(
  parameter int ADDR_BITS      = llc_bus_queue_pkg::ADDR_BITS,
  parameter int DEPTH          = 4,
  parameter int RETRY_MAX      = 3,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  llc_bus_queue_pkg::bus_op_t   req_op,
  input  logic [ADDR_BITS-1:0]         req_addr,
  output logic                         bus_valid,
  output llc_bus_queue_pkg::bus_op_t   bus_op,
  output logic [ADDR_BITS-1:0]         bus_addr,
  input  logic                         bus_ack,
  input  llc_bus_queue_pkg::snp_rslt_t bus_snoop,
  output logic                         rsp_valid,
  output llc_bus_queue_pkg::bus_op_t   rsp_op,
  output logic [ADDR_BITS-1:0]         rsp_addr,
  output llc_bus_queue_pkg::snp_rslt_t rsp_snoop,
  output logic [31:0]                  bus_ops
);

  import llc_bus_queue_pkg::*;

  localparam int FW  = 3 + ADDR_BITS;
  localparam int RCW = $clog2(RETRY_MAX + 1);
  localparam int BCW = $clog2(BACKOFF_CYCLES + 1);

  bq_state_t            state_q, state_d;
  logic [RCW-1:0]       retry_q, retry_d;
  logic [BCW-1:0]       boff_q, boff_d;
  snp_rslt_t            snoop_q, snoop_d;
  snp_rslt_t            snoop_in;
  logic [FW-1:0]        head_data;
  bus_op_t              head_op;
  logic [ADDR_BITS-1:0] head_addr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  assign req_ready = !fifo_full;
  assign head_op   = bus_op_t'(head_data[FW-1 -: 3]);
  assign head_addr = head_data[ADDR_BITS-1:0];
  assign snoop_in  = snoop_sanitize(bus_snoop);

  llc_bus_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data ({req_op, req_addr}),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      boff_q  <= '0;
      snoop_q <= HIT;
      bus_ops <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      boff_q  <= boff_d;
      snoop_q <= snoop_d;
      if (state_q == ST_ISSUE && bus_ack) bus_ops <= bus_ops + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    boff_d    = boff_q;
    snoop_d   = snoop_q;
    pop       = 1'b0;
    bus_valid = 1'b0;
    bus_op    = bus_op_t'(3'd0);
    bus_addr  = '0;
    rsp_valid = 1'b0;
    rsp_op    = bus_op_t'(3'd0);
    rsp_addr  = '0;
    rsp_snoop = HIT;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus_valid = 1'b1;
        bus_op    = head_op;
        bus_addr  = head_addr;
        if (bus_ack) begin
          snoop_d = snoop_in;
          if (op_retryable(head_op) && snoop_in == HITM && retry_q < RCW'(RETRY_MAX)) begin
            state_d = ST_BACKOFF;
            retry_d = retry_q + RCW'(1);
            boff_d  = BCW'(BACKOFF_CYCLES - 1);
          end else begin
            state_d = ST_RESPOND;
          end
        end
      end
      ST_BACKOFF: begin
        if (boff_q == '0) state_d = ST_ISSUE;
        else              boff_d  = boff_q - BCW'(1);
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        rsp_op    = head_op;
        rsp_addr  = head_addr;
        rsp_snoop = snoop_q;
        pop       = 1'b1;
        retry_d   = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_llc_bus_queue.sv
// Directed bench for llc_bus_queue: ordering, zero-wait acks, HITM retry timing, full queue, reset.
module tb_llc_bus_queue;
  import llc_bus_queue_pkg::*;

  localparam int AW = ADDR_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  bus_op_t       req_op;
  logic [AW-1:0] req_addr;
  logic          bus_valid;
  bus_op_t       bus_op;
  logic [AW-1:0] bus_addr;
  logic          bus_ack;
  snp_rslt_t     bus_snoop;
  logic          rsp_valid;
  bus_op_t       rsp_op;
  logic [AW-1:0] rsp_addr;
  snp_rslt_t     rsp_snoop;
  logic [31:0]   bus_ops;

  llc_bus_queue dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .bus_valid (bus_valid),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_ack   (bus_ack),
    .bus_snoop (bus_snoop),
    .rsp_valid (rsp_valid),
    .rsp_op    (rsp_op),
    .rsp_addr  (rsp_addr),
    .rsp_snoop (rsp_snoop),
    .bus_ops   (bus_ops)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  int            ack_cyc[$];
  logic [2:0]    ack_op[$];
  logic [AW-1:0] ack_addr[$];
  int            rsp_cyc[$];
  logic [2:0]    rsp_opq[$];
  logic [AW-1:0] rsp_addrq[$];
  logic [1:0]    rsp_snpq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid && bus_ack) begin
        ack_cyc.push_back(cyc);
        ack_op.push_back(bus_op);
        ack_addr.push_back(bus_addr);
      end
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_opq.push_back(rsp_op);
        rsp_addrq.push_back(rsp_addr);
        rsp_snpq.push_back(rsp_snoop);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    ack_cyc.delete(); ack_op.delete(); ack_addr.delete();
    rsp_cyc.delete(); rsp_opq.delete(); rsp_addrq.delete(); rsp_snpq.delete();
    rst = 1'b0;
  endtask

  // Called at posedge+1; holds the request for exactly one cycle.
  task automatic push(input bus_op_t op, input logic [AW-1:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rsp_cyc.size() >= n) break;
      step(1);
    end
    step(12);
    check(tag, rsp_cyc.size(), n);
  endtask

  int push_cyc;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = READ;
    req_addr  = '0;
    bus_ack   = 1'b0;
    bus_snoop = NOHIT;
    step(1);
    do_reset();

    check("rst_req_ready", req_ready, 1);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bus_ops",   bus_ops,   0);
    check("rst_bus_op",    bus_op,    0);
    check("rst_rsp_addr",  rsp_addr,  0);

    // Single READ, zero-wait ack
    bus_ack = 1'b1; bus_snoop = NOHIT;
    push_cyc = cyc;
    push(READ, 32'h0000_1042);
    wait_rsp("t1_rsp_cnt", 1, 30);
    if (ack_cyc.size() > 0 && rsp_cyc.size() > 0) begin
      check("t1_issue_lat", ack_cyc[0] - push_cyc, 2);
      check("t1_rsp_lat",   rsp_cyc[0] - ack_cyc[0], 1);
      check("t1_rsp_op",    rsp_opq[0],   READ);
      check("t1_rsp_addr",  rsp_addrq[0], 32'h0000_1042);
      check("t1_rsp_snp",   rsp_snpq[0],  NOHIT);
    end
    check("t1_bus_ops", bus_ops, 1);

    // Back-to-back WRITE then READ keep order
    do_reset();
    push(WRITE, 32'h0000_2000);
    push(READ,  32'h0000_3000);
    wait_rsp("t2_rsp_cnt", 2, 40);
    if (ack_cyc.size() > 1 && rsp_cyc.size() > 1) begin
      check("t2_bus0_op",   ack_op[0],   WRITE);
      check("t2_bus1_op",   ack_op[1],   READ);
      check("t2_bus1_addr", ack_addr[1], 32'h0000_3000);
      check("t2_next_gap",  ack_cyc[1] - ack_cyc[0], 3);
      check("t2_rsp0_addr", rsp_addrq[0], 32'h0000_2000);
      check("t2_rsp1_op",   rsp_opq[1],   READ);
    end
    check("t2_bus_ops", bus_ops, 2);

    // READ snooped HITM every time: 3 retries then report HITM
    do_reset();
    bus_snoop = HITM;
    push(READ, 32'h0000_4001);
    wait_rsp("t3_rsp_cnt", 1, 80);
    check("t3_attempts", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check($sformatf("t3_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
      check("t3_retry_addr", ack_addr[3], 32'h0000_4001);
    end
    if (rsp_cyc.size() > 0) begin
      check("t3_rsp_snp",  rsp_snpq[0],  HITM);
      check("t3_rsp_addr", rsp_addrq[0], 32'h0000_4001);
    end
    check("t3_bus_ops", bus_ops, 4);

    // INVALIDATE with HITM is never retried
    do_reset();
    push(INVALIDATE, 32'h0000_5000);
    wait_rsp("t4_rsp_cnt", 1, 30);
    check("t4_attempts", ack_cyc.size(), 1);
    if (rsp_cyc.size() > 0) begin
      check("t4_rsp_op",   rsp_opq[0],   INVALIDATE);
      check("t4_rsp_addr", rsp_addrq[0], 32'h0000_5000);
      check("t4_rsp_snp",  rsp_snpq[0],  HITM);
    end

    // Reserved snoop encoding behaves as NOHIT on a READ
    do_reset();
    bus_snoop = snp_rslt_t'(2'd3);
    push(READ, 32'h0000_6000);
    wait_rsp("t5_rsp_cnt", 1, 30);
    check("t5_attempts", ack_cyc.size(), 1);
    if (rsp_cyc.size() > 0) check("t5_rsp_snp", rsp_snpq[0], NOHIT);

    // Full queue: fifth push dropped
    do_reset();
    bus_ack = 1'b0; bus_snoop = NOHIT;
    push(READ,  32'h0000_7000);
    push(WRITE, 32'h0000_7040);
    push(RWIM,  32'h0000_7080);
    check("t6_ready_at3", req_ready, 1);
    push(READ,  32'h0000_70c0);
    check("t6_ready_at4", req_ready, 0);
    push(WRITE, 32'h0000_7100);
    check("t6_ready_drop", req_ready, 0);
    check("t6_no_ops", bus_ops, 0);
    bus_ack = 1'b1;
    wait_rsp("t6_rsp_cnt", 4, 60);
    if (rsp_cyc.size() == 4) begin
      check("t6_rsp0_addr", rsp_addrq[0], 32'h0000_7000);
      check("t6_rsp2_op",   rsp_opq[2],   RWIM);
      check("t6_rsp3_addr", rsp_addrq[3], 32'h0000_70c0);
    end
    check("t6_bus_ops", bus_ops, 4);
    check("t6_ready_end", req_ready, 1);

    // Reset while issuing with 3 queued entries
    do_reset();
    bus_ack = 1'b0;
    push(READ,  32'h0000_8000);
    push(WRITE, 32'h0000_8040);
    push(READ,  32'h0000_8080);
    check("t7_issuing", bus_valid, 1);
    rst = 1'b1;
    step(1);
    check("t7_bus_valid", bus_valid, 0);
    check("t7_rsp_valid", rsp_valid, 0);
    check("t7_req_ready", req_ready, 1);
    check("t7_bus_ops",   bus_ops,   0);
    rst = 1'b0;
    bus_ack = 1'b1;
    step(15);
    check("t7_no_issue", ack_cyc.size(), 0);
    check("t7_no_rsp",   rsp_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
